boot_loader: RTL

Program loader sitting upstream of the SUBLEQ core on the shared memory bus. After reset it owns the bus and accepts a byte stream: a word-count header followed by the program image. It writes the image into memory as 32-bit words, then hands the bus to the core by asserting `cpu_en` and releasing the core's reset. A `boot_req` pulse reclaims the bus and reloads.

---
 rtl/boot_loader_pkg.sv | 22 ++
 rtl/boot_loader_byte_packer.sv | 37 +++
 rtl/boot_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the program loader: FSM states and the
// byte-lane conventions used when handing an image to the core.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } state_t;

    // Stream byte k of a word lands in memory lane k (bits 8k+7:8k).
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;

    // Reinterpret a lane-ordered word as an MSB-first value.
    function automatic logic [31:0] msb_first(input logic [31:0] lanes);
        return {lanes[7:0], lanes[15:8], lanes[23:16], lanes[31:24]};
    endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Assembles four stream bytes into one word in memory lane order.
// word/word_done are valid in the cycle the fourth byte is presented.
module byte_packer
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int unsigned HOLD_W = LANE_W * (WORD_BYTES - 1);

    logic [1:0]        cnt;
    logic [HOLD_W-1:0] hold;

    assign word      = {byte_in, hold};
    assign word_done = byte_valid && (cnt == 2'(WORD_BYTES - 1));

    // Shift earlier bytes down so the first one ends up in lane 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            hold <= '0;
        end else if (clr) begin
            cnt  <= '0;
            hold <= '0;
        end else if (byte_valid) begin
            cnt  <= cnt + 2'd1;
            hold <= {byte_in, hold[HOLD_W-1:LANE_W]};
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed program image into memory over the shared
// bus, then hands the bus to the core and releases its reset.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] MAX_WORDS = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        boot_req,
    output logic        cpu_en,
    output logic        core_rst_n,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire logic [31:0] mem_data
);

    state_t      state, state_nx;
    logic [31:0] n_words;
    logic [31:0] index;
    logic [31:0] wdata;
    logic [31:0] pk_word;
    logic [31:0] hdr_n;
    logic        pk_done;
    logic        xfer;
    logic        reload;
    logic        we_int;
    logic [31:0] addr_int;

    assign rx_ready = rst && (state == ST_HDR || state == ST_DATA);
    assign xfer     = rx_valid && rx_ready;
    assign reload   = boot_req && (state == ST_RUN || state == ST_ERR);
    assign hdr_n    = msb_first(pk_word);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (reload),
        .byte_in    (rx_data),
        .byte_valid (xfer),
        .word       (pk_word),
        .word_done  (pk_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_HDR;
        else      state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            ST_HDR: begin
                if (pk_done) begin
                    if (hdr_n == '0)           state_nx = ST_RUN;
                    else if (hdr_n > MAX_WORDS) state_nx = ST_ERR;
                    else                       state_nx = ST_DATA;
                end
            end
            ST_DATA:  if (pk_done) state_nx = ST_WRITE;
            ST_WRITE: state_nx = (index + 32'd1 < n_words) ? ST_DATA : ST_RUN;
            ST_RUN:   if (boot_req) state_nx = ST_HDR;
            ST_ERR:   if (boot_req) state_nx = ST_HDR;
            default:  state_nx = ST_HDR;
        endcase
    end

    // Counters, write data and handoff flags; flags follow the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_words    <= '0;
            index      <= '0;
            wdata      <= '0;
            cpu_en     <= 1'b0;
            core_rst_n <= 1'b0;
            err        <= 1'b0;
        end else begin
            cpu_en     <= (state_nx == ST_RUN);
            core_rst_n <= (state_nx == ST_RUN);
            err        <= (state_nx == ST_ERR);
            if (reload) begin
                n_words <= '0;
                index   <= '0;
            end else if (state == ST_HDR && pk_done) begin
                n_words <= hdr_n;
                index   <= '0;
            end else if (state == ST_WRITE) begin
                index <= index + 32'd1;
            end
            if (state == ST_DATA && pk_done) wdata <= pk_word;
        end
    end

    assign we_int   = (state == ST_WRITE);
    assign addr_int = we_int ? BASE_ADDR + (index << 2) : '0;

    assign mem_we   = cpu_en ? 1'bz : we_int;
    assign mem_addr = cpu_en ? 'z : addr_int;
    assign mem_data = (!cpu_en && we_int) ? wdata : 'z;

endmodule
